// File: rtl/regfile_seq.sv
// regfile_seq -- four-word, 8-bit register file that keeps its storage in an
// external single-port synchronous RAM and sequences reads and writebacks
// through a small FSM.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      asynchronous active-low reset, released synchronously to clk
//   op_valid   operand-read request; accepted when op_valid & op_ready
//   op_ready   high only in IDLE when no writeback is requesting
//   rs, rt     operand register indices (2 bits each)
//   rd_valid   one-cycle pulse when rs_data/rt_data carry the new operands
//   rs_data    first operand value
//   rt_data    second operand value
//   wb_valid   writeback request; accepted when wb_valid & wb_ready
//   wb_ready   high only in IDLE
//   wb_ad      writeback register index
//   wb_data    writeback value
//   ram_ce     RAM clock enable
//   ram_oce    RAM output enable, tied high
//   ram_wre    RAM write enable (1 write, 0 read)
//   ram_ad     RAM word address
//   ram_din    RAM write data
//   ram_dout   RAM read data, valid the cycle after a read address cycle

module regfile_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] rs,
  input  logic [1:0] rt,
  output logic       rd_valid,
  output logic [7:0] rs_data,
  output logic [7:0] rt_data,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [1:0] wb_ad,
  input  logic [7:0] wb_data,
  output logic       ram_ce,
  output logic       ram_oce,
  output logic       ram_wre,
  output logic [1:0] ram_ad,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic [2:0] {
    CLR  = 3'd0,
    IDLE = 3'd1,
    RD_A = 3'd2,
    RD_B = 3'd3,
    CAP  = 3'd4,
    WR   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] clr_cnt;
  logic [1:0] rs_lat;
  logic [1:0] rt_lat;
  logic [1:0] wb_ad_lat;
  logic [7:0] wb_data_lat;
  logic [1:0] ad_last;
  logic [7:0] din_last;
  logic       ce_c;
  logic       wre_c;

  // State register, request latches and operand capture. ad_last/din_last
  // remember what was last put on the RAM bus so idle cycles can hold it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLR;
      clr_cnt     <= 2'd0;
      rs_lat      <= 2'd0;
      rt_lat      <= 2'd0;
      wb_ad_lat   <= 2'd0;
      wb_data_lat <= 8'h00;
      ad_last     <= 2'd0;
      din_last    <= 8'h00;
      rd_valid    <= 1'b0;
      rs_data     <= 8'h00;
      rt_data     <= 8'h00;
    end else begin
      state    <= state_nxt;
      ad_last  <= ram_ad;
      din_last <= ram_din;
      rd_valid <= (state == CAP);
      if (state == CLR) begin
        clr_cnt <= clr_cnt + 2'd1;
      end
      if (state == IDLE) begin
        if (wb_valid) begin
          wb_ad_lat   <= wb_ad;
          wb_data_lat <= wb_data;
        end else if (op_valid) begin
          rs_lat <= rs;
          rt_lat <= rt;
        end
      end
      // ram_dout lags the address by one cycle: the rs word arrives during
      // RD_B and the rt word during CAP.
      if (state == RD_B) begin
        rs_data <= ram_dout;
      end
      if (state == CAP) begin
        rt_data <= ram_dout;
      end
    end
  end

  // Next-state and RAM bus decode. Address and data default to the last
  // driven values so the bus stays quiet while idle.
  always_comb begin
    state_nxt = state;
    ce_c      = 1'b0;
    wre_c     = 1'b0;
    ram_ad    = ad_last;
    ram_din   = din_last;
    case (state)
      CLR: begin
        ce_c    = 1'b1;
        wre_c   = 1'b1;
        ram_ad  = clr_cnt;
        ram_din = 8'h00;
        if (clr_cnt == 2'd3) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (wb_valid) begin
          state_nxt = WR;
        end else if (op_valid) begin
          state_nxt = RD_A;
        end
      end
      WR: begin
        ce_c      = 1'b1;
        wre_c     = 1'b1;
        ram_ad    = wb_ad_lat;
        ram_din   = wb_data_lat;
        state_nxt = IDLE;
      end
      RD_A: begin
        ce_c      = 1'b1;
        ram_ad    = rs_lat;
        state_nxt = RD_B;
      end
      RD_B: begin
        ce_c      = 1'b1;
        ram_ad    = rt_lat;
        state_nxt = CAP;
      end
      CAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = CLR;
      end
    endcase
  end

  // The state register sits in CLR while reset is held, yet the RAM must not
  // see write strobes until reset is released, so the strobes are qualified
  // with the reset level itself.
  always_comb begin
    ram_ce   = ce_c & reset;
    ram_wre  = wre_c & reset;
    ram_oce  = 1'b1;
    wb_ready = (state == IDLE);
    op_ready = (state == IDLE) & ~wb_valid;
  end

endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq -- directed bench for regfile_seq with an attached
// synchronous RAM, a transaction-level reference model of the register file
// and a per-cycle output comparison, plus literal expectations per scenario.

module tb_regfile_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] rs = 2'd0;
  logic [1:0] rt = 2'd0;
  logic       rd_valid;
  logic [7:0] rs_data;
  logic [7:0] rt_data;
  logic       wb_valid = 1'b0;
  logic       wb_ready;
  logic [1:0] wb_ad = 2'd0;
  logic [7:0] wb_data = 8'h00;
  logic       ram_ce;
  logic       ram_oce;
  logic       ram_wre;
  logic [1:0] ram_ad;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checksTotal = 0;
  int checksPassed = 0;

  regfile_seq dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .rs(rs), .rt(rt),
    .rd_valid(rd_valid), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_ad(wb_ad), .wb_data(wb_data),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial forever #5 clk = ~clk;

  // External synchronous RAM, seeded with junk so the clear pass matters.
  logic [7:0] ramMem [4];
  logic [7:0] ramOut = 8'hEE;
  assign ram_dout = ramOut;
  initial for (int i = 0; i < 4; i++) ramMem[i] = 8'hE0 + 8'(i);
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) ramMem[ram_ad] <= ram_din;
      else ramOut <= ramMem[ram_ad];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: register contents plus "cycles of work remaining" for
  // the clear pass, a writeback and a read.
  logic [7:0] mMem [4];
  int         mClrLeft = 4;
  int         mWrLeft = 0;
  int         mRdLeft = 0;
  logic [1:0] mRs = 2'd0, mRt = 2'd0, mWad = 2'd0, mLastAd = 2'd0;
  logic [7:0] mWdata = 8'h00, mLastDin = 8'h00, mRsData = 8'h00, mRtData = 8'h00;
  logic       mRdValid = 1'b0;

  initial begin
    for (int i = 0; i < 4; i++) mMem[i] = 8'h00;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mClrLeft = 4; mWrLeft = 0; mRdLeft = 0;
        mRs = 2'd0; mRt = 2'd0; mWad = 2'd0; mLastAd = 2'd0;
        mWdata = 8'h00; mLastDin = 8'h00; mRsData = 8'h00; mRtData = 8'h00;
        mRdValid = 1'b0;
      end else begin
        mRdValid = 1'b0;
        if (mClrLeft > 0) begin
          mLastAd = 2'(4 - mClrLeft);
          mMem[mLastAd] = 8'h00;
          mLastDin = 8'h00;
          mClrLeft--;
        end else if (mWrLeft > 0) begin
          mMem[mWad] = mWdata;
          mLastAd = mWad;
          mLastDin = mWdata;
          mWrLeft = 0;
        end else if (mRdLeft > 0) begin
          if (mRdLeft == 3) mLastAd = mRs;
          else if (mRdLeft == 2) begin
            mLastAd = mRt;
            mRsData = mMem[mRs];
          end else begin
            mRtData = mMem[mRt];
            mRdValid = 1'b1;
          end
          mRdLeft--;
        end else if (wb_valid) begin
          mWrLeft = 1; mWad = wb_ad; mWdata = wb_data;
        end else if (op_valid) begin
          mRdLeft = 3; mRs = rs; mRt = rt;
        end
      end
    end
  end

  // Every cycle: derive the expected bus and handshake values from the model.
  initial forever begin
    logic eCe, eWre, eOpRdy, eWbRdy;
    logic [1:0] eAd;
    logic [7:0] eDin;
    @(negedge clk);
    eCe = 1'b0; eWre = 1'b0; eOpRdy = 1'b0; eWbRdy = 1'b0;
    eAd = mLastAd; eDin = mLastDin;
    if (!reset) begin
      eAd = 2'd0; eDin = 8'h00;
    end else if (mClrLeft > 0) begin
      eCe = 1'b1; eWre = 1'b1; eAd = 2'(4 - mClrLeft); eDin = 8'h00;
    end else if (mWrLeft > 0) begin
      eCe = 1'b1; eWre = 1'b1; eAd = mWad; eDin = mWdata;
    end else if (mRdLeft == 3) begin
      eCe = 1'b1; eAd = mRs;
    end else if (mRdLeft == 2) begin
      eCe = 1'b1; eAd = mRt;
    end else if (mRdLeft == 0) begin
      eWbRdy = 1'b1; eOpRdy = ~wb_valid;
    end
    checkOutput("op_ready", op_ready, eOpRdy);
    checkOutput("wb_ready", wb_ready, eWbRdy);
    checkOutput("rd_valid", rd_valid, mRdValid);
    checkOutput("rs_data", rs_data, mRsData);
    checkOutput("rt_data", rt_data, mRtData);
    checkOutput("ram_ce", ram_ce, eCe);
    checkOutput("ram_oce", ram_oce, 1'b1);
    checkOutput("ram_wre", ram_wre, eWre);
    checkOutput("ram_ad", ram_ad, eAd);
    checkOutput("ram_din", ram_din, eDin);
  end

  task automatic applyStimulus(input logic ov, input logic [1:0] a, input logic [1:0] b,
                               input logic wv, input logic [1:0] wa, input logic [7:0] wd);
    @(posedge clk);
    #1;
    op_valid = ov; rs = a; rt = b;
    wb_valid = wv; wb_ad = wa; wb_data = wd;
  endtask

  // Waits for an already-driven read to be accepted, then checks latency and data.
  task automatic waitRead(input logic [7:0] ea, input logic [7:0] eb, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!op_ready && n < 20);
    checkOutput($sformatf("%s_accept", tag), op_ready, 1'b1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_valid && n < 10);
    checkOutput($sformatf("%s_latency", tag), n, 4);
    checkOutput($sformatf("%s_rs", tag), rs_data, ea);
    checkOutput($sformatf("%s_rt", tag), rt_data, eb);
  endtask

  task automatic readOp(input logic [1:0] a, input logic [1:0] b,
                        input logic [7:0] ea, input logic [7:0] eb, input string tag);
    applyStimulus(1'b1, a, b, 1'b0, 2'd0, 8'h00);
    waitRead(ea, eb, tag);
  endtask

  task automatic writeOp(input logic [1:0] wa, input logic [7:0] wd);
    int n = 0;
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, wa, wd);
    do begin @(negedge clk); n++; end while (!wb_ready && n < 20);
    checkOutput("wb_accept", wb_ready, 1'b1);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    int n;
    int acc[$];
    int cyc;

    // Reset values, then clear pass and first ready cycle.
    @(negedge clk);
    checkOutput("reset_ram_wre", ram_wre, 1'b0);
    checkOutput("reset_op_ready", op_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!op_ready && n < 20);
    checkOutput("first_op_ready_cycle", n, 5);
    readOp(2'd2, 2'd3, 8'h00, 8'h00, "rd_cleared");

    // Two writebacks, then read them back; same-register read.
    writeOp(2'd1, 8'hA5);
    writeOp(2'd2, 8'h3C);
    readOp(2'd1, 2'd2, 8'hA5, 8'h3C, "rd_after_wr");
    readOp(2'd1, 2'd1, 8'hA5, 8'hA5, "rd_same");

    // Simultaneous writeback and read: write wins, read sees the new word.
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd0, 8'h77);
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ready && n < 20);
    checkOutput("collide_wb_ready", wb_ready, 1'b1);
    checkOutput("collide_op_ready", op_ready, 1'b0);
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    waitRead(8'h77, 8'h77, "rd_collide");

    // Held op_valid: acceptances spaced four cycles apart.
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    for (cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (op_ready) acc.push_back(cyc);
    end
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    checkOutput("b2b_count", acc.size() >= 3, 1'b1);
    if (acc.size() >= 3) begin
      checkOutput("b2b_gap1", acc[1] - acc[0], 4);
      checkOutput("b2b_gap2", acc[2] - acc[1], 4);
    end
    repeat (6) @(posedge clk);

    // Reset during RD_B: no pulse, outputs cleared, contents re-zeroed.
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!op_ready && n < 20);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_rs_data", rs_data, 8'h00);
    checkOutput("abort_rt_data", rt_data, 8'h00);
    checkOutput("abort_ram_ce", ram_ce, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("restart_clr_ad", ram_ad, 2'd0);
    checkOutput("restart_clr_wre", ram_wre, 1'b1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_valid) n++;
    end
    checkOutput("abort_no_pulse", n, 0);
    readOp(2'd1, 2'd2, 8'h00, 8'h00, "rd_after_reclear");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, released synchronously to clk.
REQ-003 op_valid  input  1  operand-read request.
REQ-004 op_ready  output  1  request accepted when op_valid & op_ready at a rising edge.
REQ-005 rs  input  2  first operand register index.
REQ-006 rt  input  2  second operand register index.
REQ-007 rd_valid  output  1  one-cycle pulse: rs_data/rt_data valid.
REQ-008 rs_data  output  8  first operand value.
REQ-009 rt_data  output  8  second operand value.
REQ-010 wb_valid  input  1  writeback request.
REQ-011 wb_ready  output  1  writeback accepted when wb_valid & wb_ready at a rising edge.
REQ-012 wb_ad  input  2  writeback register index.
REQ-013 wb_data  input  8  writeback value.
REQ-014 ram_ce  output  1  RAM clock enable.
REQ-015 ram_oce  output  1  RAM output enable; constant 1.
REQ-016 ram_wre  output  1  RAM write enable (1 write, 0 read).
REQ-017 ram_ad  output  2  RAM word address.
REQ-018 ram_din  output  8  RAM write data.
REQ-019 ram_dout  input  8  RAM read data; valid the cycle after the address cycle (ram_ce=1, ram_wre=0).

Function
REQ-020 FSM states: CLR, IDLE, RD_A, RD_B, CAP, WR.
REQ-021 CLR: 2-bit clr_cnt 0..3; each cycle ram_ce=1, ram_wre=1, ram_ad=clr_cnt, ram_din=0x00; after clr_cnt=3 -> IDLE (4 cycles total).
REQ-022 wb_ready = (state==IDLE); op_ready = (state==IDLE) & ~wb_valid; both 0 in every other state.
REQ-023 IDLE with wb_valid=1: latch wb_ad/wb_data -> WR; writeback has priority over a simultaneous op_valid, which stays pending.
REQ-024 WR: ram_ce=1, ram_wre=1, ram_ad=latched wb_ad, ram_din=latched wb_data; -> IDLE next cycle.
REQ-025 IDLE with op_valid=1, wb_valid=0: latch rs, rt -> RD_A.
REQ-026 RD_A: ram_ce=1, ram_wre=0, ram_ad=rs latch -> RD_B.
REQ-027 RD_B: ram_ce=1, ram_wre=0, ram_ad=rt latch; rs_data <= ram_dout at end of cycle -> CAP.
REQ-028 CAP: ram_ce=0; rt_data <= ram_dout at end of cycle; rd_valid=1 in the following IDLE cycle only -> IDLE.
REQ-029 Latency: acceptance edge to rd_valid high = 4 clk; throughput one read per 4 cycles, one write per 2 cycles.
REQ-030 rs_data/rt_data hold their values until the next capture; unaffected by writebacks.
REQ-031 rs==rt is legal; both outputs carry the same word, read twice.
REQ-032 A read accepted in the cycle right after WR returns the newly written value (write committed before RD_A).
REQ-033 IDLE with no request: ram_ce=0, ram_wre=0; ram_ad/ram_din hold last values.
REQ-034 ram_oce driven 1 in all states, including reset.

Reset
REQ-035 On reset=0: state=CLR, clr_cnt=0, rd_valid=0, rs_data=0x00, rt_data=0x00, latches=0, op_ready=0, wb_ready=0, ram_wre=0, ram_ce=0, ram_ad=0, ram_din=0x00.
REQ-036 Reset asserted mid-operation (any state) aborts it; no rd_valid pulse; CLR re-runs after release, re-zeroing all 4 words.
REQ-037 First cycle after release is the first CLR cycle (ram_ad=0, ram_wre=1).

Verification
REQ-038 Release reset -> 4 CLR writes of 0x00 to addresses 0,1,2,3; op_ready first high on cycle 5; read rs=2,rt=3 returns 0x00,0x00.
REQ-039 Write 0xA5 to 1, 0x3C to 2, then read rs=1,rt=2 -> rd_valid one cycle, rs_data=0xA5, rt_data=0x3C, 4 cycles after acceptance.
REQ-040 wb_valid and op_valid together in IDLE (wb_ad=0, wb_data=0x77; rs=0,rt=0) -> write first, op_ready=0 that cycle, read then returns 0x77,0x77.
REQ-041 Back-to-back ops with op_valid held high -> accepted every 4th cycle; op_ready low in RD_A/RD_B/CAP.
REQ-042 Assert reset during RD_B -> no rd_valid; outputs 0x00; after release CLR repeats, prior contents (e.g. 0xA5 at 1) read back as 0x00.
